fpu_issue_ctrl: RTL

- Sequences a single fpu_arithmetic_top instance on behalf of the core.
- Accepts one FP operation at a time over a valid/ready request channel and registers its operands.
- Holds the FPU start signal high until done is seen, then captures the result and exception flags and returns them over a valid/ready response channel.
- Owns the sticky fflags and frm state, a flush path and a watchdog.

---
 rtl/fpu_issue_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue/response sequencer for a single fpu_arithmetic_top instance.
// Owns the sticky fflags/frm CSRs, flush handling and a BUSY watchdog.
module fpu_issue_ctrl #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_rs2_lsb,
    input  logic [TAG_W-1:0] req_tag,
    // response channel
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    // control / CSR
    input  logic             flush,
    input  logic             csr_we,
    input  logic             csr_sel,
    input  logic [4:0]       csr_wdata,
    output logic [4:0]       fflags,
    output logic [2:0]       frm,
    // FPU side
    output logic             fpu_start,
    output logic             fpu_reset,
    output logic [4:0]       fpu_op,
    output logic [2:0]       fpu_rm,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_rs2_lsb,
    input  logic [31:0]      fpu_out,
    input  logic             fpu_done,
    input  logic [4:0]       fpu_flags
);

    localparam int unsigned    WdW    = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [31:0]    QNaN   = 32'h7FC00000;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             rs2_q, rs2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [2:0]       frm_q, frm_d;
    logic [WdW-1:0]   wdog_q, wdog_d;
    logic             fpu_rst_q, fpu_rst_d;

    logic             rm_bad;
    logic [4:0]       fflags_base;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rm_d      = rm_q;
        a_d       = a_q;
        b_d       = b_q;
        rs2_d     = rs2_q;
        tag_d     = tag_q;
        data_d    = data_q;
        err_d     = err_q;
        frm_d     = frm_q;
        wdog_d    = wdog_q;
        fpu_rst_d = 1'b0;

        // Dynamic mode resolves through the current frm; 101..111 are reserved.
        rm_bad = (req_rm == 3'b101) || (req_rm == 3'b110) ||
                 ((req_rm == 3'b111) && (frm_q >= 3'b101));

        // A software fflags write is the base that a same-cycle capture ORs into.
        fflags_base = (csr_we && !csr_sel) ? csr_wdata : fflags_q;
        fflags_d    = fflags_base;
        if (csr_we && csr_sel) begin
            frm_d = csr_wdata[2:0];
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid && !flush) begin
                    op_d  = req_op;
                    rm_d  = req_rm;
                    a_d   = req_a;
                    b_d   = req_b;
                    rs2_d = req_rs2_lsb;
                    tag_d = req_tag;
                    if (rm_bad) begin
                        data_d  = 32'h0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        wdog_d  = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush) begin
                    fpu_rst_d = 1'b1;
                    state_d   = StIdle;
                end else if (fpu_done) begin
                    data_d   = fpu_out;
                    err_d    = 1'b0;
                    fflags_d = fflags_base | fpu_flags;
                    state_d  = StResp;
                end else if (wdog_q == WdLast) begin
                    data_d    = QNaN;
                    err_d     = 1'b1;
                    fflags_d  = fflags_base | 5'b10000;
                    fpu_rst_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StResp: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rm_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rs2_q     <= 1'b0;
            tag_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            fflags_q  <= '0;
            frm_q     <= '0;
            wdog_q    <= '0;
            fpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rs2_q     <= rs2_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            err_q     <= err_d;
            fflags_q  <= fflags_d;
            frm_q     <= frm_d;
            wdog_q    <= wdog_d;
            fpu_rst_q <= fpu_rst_d;
        end
    end

    assign req_ready   = (state_q == StIdle) && !flush;
    assign resp_valid  = (state_q == StResp);
    assign resp_data   = data_q;
    assign resp_tag    = tag_q;
    assign resp_err    = err_q;
    assign fflags      = fflags_q;
    assign frm         = frm_q;
    assign fpu_start   = (state_q == StBusy);
    assign fpu_reset   = reset | fpu_rst_q;
    assign fpu_op      = op_q;
    assign fpu_rm      = rm_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign fpu_rs2_lsb = rs2_q;

endmodule
